// File: rtl/spi_master_pkg.sv
// Shared constants for the SPI master and its half-period timer.
// Holds the FSM state encoding and the default SCLK half-period length.
package spi_master_pkg;

  localparam int unsigned HALF_PERIOD_DEFAULT = 1;
  localparam int          CNT_W               = 4;
  localparam int          BIT_W               = 3;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    XFER_LOW   = 3'd1,
    XFER_HIGH  = 3'd2,
    DUMMY_LOW  = 3'd3,
    DUMMY_HIGH = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_master_clk_div.sv
// Half-period timer: counts clk cycles and emits a one-cycle tick at terminal count.
// Holding start high keeps the count parked at zero so each phase begins aligned.
module spi_clk_div
  import spi_master_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = HALF_PERIOD_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic tick
);

  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0] count;

  // Wrapping on tick lets consecutive phases run back to back without a restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (start || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = !start && (count == TERMINAL);

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: 8-bit MSB-first transfers plus single dummy SCLK pulses.
// HALF_PERIOD sets the clk cycles spent in each SCLK half-period.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = HALF_PERIOD_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_tx,
  output logic [7:0] data_rx,
  input  logic       txn_start,
  output logic       txn_done,
  input  logic       force_clock,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  spi_state_e       state, state_nxt;
  logic [7:0]       shift_reg, shift_nxt;
  logic [7:0]       rx_nxt;
  logic [BIT_W-1:0] bit_cnt, bit_nxt;
  logic             mosi_nxt;
  logic             tick;
  logic             div_start;

  assign div_start = (state == IDLE);

  spi_clk_div #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_clk_div (
    .clk  (clk),
    .rst_n(rst_n),
    .start(div_start),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      data_rx   <= '0;
      spi_mosi  <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      bit_cnt   <= bit_nxt;
      data_rx   <= rx_nxt;
      spi_mosi  <= mosi_nxt;
    end
  end

  // MISO enters the shift LSB on the rising SCLK edge; MOSI advances on the falling one.
  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    bit_nxt   = bit_cnt;
    rx_nxt    = data_rx;
    mosi_nxt  = spi_mosi;
    unique case (state)
      IDLE: begin
        if (txn_start) begin
          shift_nxt = data_tx;
          bit_nxt   = '0;
          mosi_nxt  = data_tx[7];
          state_nxt = XFER_LOW;
        end else if (force_clock) begin
          state_nxt = DUMMY_LOW;
        end
      end
      XFER_LOW: begin
        if (tick) begin
          shift_nxt = {shift_reg[6:0], spi_miso};
          state_nxt = XFER_HIGH;
        end
      end
      XFER_HIGH: begin
        if (tick) begin
          bit_nxt = bit_cnt + 1'b1;
          if (bit_cnt == BIT_W'(7)) begin
            rx_nxt    = shift_reg;
            state_nxt = IDLE;
          end else begin
            mosi_nxt  = shift_reg[7];
            state_nxt = XFER_LOW;
          end
        end
      end
      DUMMY_LOW: begin
        if (tick) state_nxt = DUMMY_HIGH;
      end
      DUMMY_HIGH: begin
        if (tick) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign txn_done = (state == IDLE);
  assign spi_clk  = (state == XFER_HIGH) || (state == DUMMY_HIGH);

endmodule
